// File: rtl/uart_rx_core_pkg.sv
// Shared definitions for the UART receive path: LSR bit positions, receiver
// states and the frame payload width.
package uart_rx_core_pkg;

  localparam int FRAME_BITS = 8;

  localparam int LSR_DA  = 0;
  localparam int LSR_OE  = 1;
  localparam int LSR_PE  = 2;
  localparam int LSR_SOK = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    WAIT_IDLE
  } rx_state_t;

  function automatic logic even_parity(input logic [FRAME_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock FIFO with registered read port and registered empty/full flags.
module rx_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic             wr_ok;
  logic             rd_ok;

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_comb begin
    count_next = count_reg;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      rd_data    <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        rd_data    <= mem[rd_ptr_reg];
      end
      count_reg <= count_next;
      empty     <= (count_next == '0);
      full      <= (count_next == (AW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampling tick, 8E2 frame FSM, and a FIFO of
// {data, LSR} entries for the host.
module uart_rx_core #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  input  logic        rd_en,
  output logic [15:0] read_data,
  output logic        empty,
  output logic        full
);

  import uart_rx_core_pkg::*;

  localparam int DIVISOR = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W   = $clog2(DIVISOR);
  localparam int OS_W    = $clog2(OVERSAMPLE);
  localparam int BIT_W   = $clog2(FRAME_BITS);

  logic [DIV_W-1:0]      div_cnt_reg;
  logic                  tick_reg;
  logic                  rx_meta_reg;
  logic                  rx_sync_reg;
  rx_state_t             state_reg;
  logic [OS_W-1:0]       os_cnt_reg;
  logic [BIT_W-1:0]      bit_cnt_reg;
  logic [FRAME_BITS-1:0] shift_reg;
  logic                  parity_err_reg;
  logic                  stop1_reg;
  logic                  stop_ok_reg;
  logic                  frame_done_reg;
  logic                  overrun_reg;
  logic                  sample_pt;
  logic                  wr_en;
  logic [7:0]            lsr;

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt_reg <= '0;
      tick_reg    <= 1'b0;
    end else if (div_cnt_reg == DIV_W'(DIVISOR - 1)) begin
      div_cnt_reg <= '0;
      tick_reg    <= 1'b1;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
      tick_reg    <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  // Start is confirmed half a bit in; every later sample lands a full bit after.
  always_comb begin
    sample_pt = 1'b0;
    if (tick_reg) begin
      if (state_reg == START) sample_pt = (os_cnt_reg == OS_W'(OVERSAMPLE/2 - 1));
      else                    sample_pt = (os_cnt_reg == OS_W'(OVERSAMPLE - 1));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      os_cnt_reg     <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      parity_err_reg <= 1'b0;
      stop1_reg      <= 1'b0;
      stop_ok_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (state_reg == IDLE || state_reg == WAIT_IDLE) os_cnt_reg <= '0;
      else if (tick_reg) os_cnt_reg <= sample_pt ? '0 : os_cnt_reg + 1'b1;

      case (state_reg)
        IDLE: if (!rx_sync_reg) state_reg <= START;
        START: if (sample_pt) begin
          bit_cnt_reg <= '0;
          state_reg   <= rx_sync_reg ? IDLE : DATA;
        end
        DATA: if (sample_pt) begin
          shift_reg <= {rx_sync_reg, shift_reg[FRAME_BITS-1:1]};
          if (bit_cnt_reg == BIT_W'(FRAME_BITS - 1)) state_reg <= PARITY;
          else bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
        PARITY: if (sample_pt) begin
          parity_err_reg <= (rx_sync_reg != even_parity(shift_reg));
          state_reg      <= STOP1;
        end
        STOP1: if (sample_pt) begin
          stop1_reg <= rx_sync_reg;
          state_reg <= STOP2;
        end
        STOP2: if (sample_pt) begin
          stop_ok_reg    <= stop1_reg & rx_sync_reg;
          frame_done_reg <= 1'b1;
          state_reg      <= (stop1_reg & rx_sync_reg) ? IDLE : WAIT_IDLE;
        end
        WAIT_IDLE: if (rx_sync_reg) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    lsr          = '0;
    lsr[LSR_DA]  = 1'b1;
    lsr[LSR_OE]  = overrun_reg;
    lsr[LSR_PE]  = parity_err_reg;
    lsr[LSR_SOK] = stop_ok_reg;
  end

  assign wr_en = frame_done_reg && !full;

  // Overrun is sticky until it has been reported in a stored entry.
  always_ff @(posedge clock) begin
    if (reset)               overrun_reg <= 1'b0;
    else if (frame_done_reg) overrun_reg <= full;
  end

  rx_sync_fifo #(
    .WIDTH(16),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_data({shift_reg, lsr}),
    .rd_en  (rd_en),
    .rd_data(read_data),
    .empty  (empty),
    .full   (full)
  );

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomised and directed bench for uart_rx_core with a queue-based scoreboard
// fed by a frame-level model and drained by a read monitor.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int CLK_FREQ   = 614400;
  localparam int BAUD_RATE  = 9600;
  localparam int OVERSAMPLE = 16;
  localparam int FIFO_DEPTH = 16;
  localparam int BIT        = CLK_FREQ / BAUD_RATE;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx    = 1'b1;
  logic        rd_en = 1'b0;
  logic [15:0] read_data;
  logic        empty;
  logic        full;

  logic [15:0] exp_q[$];
  logic [15:0] last_exp = 16'h0000;
  bit          model_oe = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clock = ~clock;

  uart_rx_core #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .rd_en    (rd_en),
    .read_data(read_data),
    .empty    (empty),
    .full     (full)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic bit_out(input logic v);
    rx = v;
    repeat (BIT) @(posedge clock);
    #1;
  endtask

  // Drives one serial frame, then records what the receiver should store.
  task automatic send_frame(input logic [7:0] d, input bit pflip, input bit s1,
                            input bit s2, input int extra_low);
    logic pbit;
    pbit = (^d) ^ pflip;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    bit_out(pbit);
    bit_out(s1);
    bit_out(s2);
    if (extra_low > 0) begin
      rx = 1'b0;
      repeat (extra_low) @(posedge clock);
      #1;
    end
    rx = 1'b1;
    if (exp_q.size() == FIFO_DEPTH) begin
      model_oe = 1'b1;
    end else begin
      exp_q.push_back({d, 4'b0000, s1 & s2, pbit != (^d), model_oe, 1'b1});
      model_oe = 1'b0;
    end
    $display("frame: data=%h pflip=%0d stop=%0d%0d queued=%0d", d, pflip, s1, s2, exp_q.size());
    repeat (BIT) @(posedge clock);
    #1;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(posedge clock);
    #2;
    rd_en = 1'b0;
  endtask

  // Monitor: every sampled read request is scored against the model queue.
  always @(posedge clock) begin
    if (!reset && rd_en) begin
      if (exp_q.size() > 0) last_exp = exp_q.pop_front();
      #1;
      $display("pop: read_data=%h empty=%b full=%b", read_data, empty, full);
      chk("read_data", read_data, last_exp);
      chk("empty_after_pop", 16'(empty), 16'(exp_q.size() == 0));
    end
  end

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: got timeout, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    bit         pf, s1, s2;
    int         extra, n_pop;

    repeat (5) @(posedge clock);
    #1;
    chk("reset_empty", 16'(empty), 16'h0001);
    chk("reset_full", 16'(full), 16'h0000);
    chk("reset_read_data", read_data, 16'h0000);
    reset = 1'b0;
    repeat (2 * BIT) @(posedge clock);
    #1;

    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 0);
    pop();
    chk("clean_a5", read_data, 16'hA509);
    chk("clean_a5_empty", 16'(empty), 16'h0001);

    rx = 1'b0;
    repeat (BIT / 3) @(posedge clock);
    #1;
    rx = 1'b1;
    repeat (2 * BIT) @(posedge clock);
    #1;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 0);
    pop();
    chk("glitch_5a", read_data, 16'h5A09);
    chk("glitch_one_entry", 16'(empty), 16'h0001);
    pop();
    chk("pop_empty_holds", read_data, 16'h5A09);

    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 0);
    pop();
    chk("parity_3c", read_data, 16'h3C0D);

    send_frame(8'h81, 1'b0, 1'b0, 1'b0, BIT / 2);
    send_frame(8'h42, 1'b0, 1'b1, 1'b1, 0);
    pop();
    chk("framing_81", read_data, 16'h8101);
    pop();
    chk("framing_42", read_data, 16'h4209);
    chk("framing_no_extra", 16'(empty), 16'h0001);

    for (int i = 0; i < FIFO_DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b1, 0);
    chk("overrun_full16", 16'(full), 16'h0001);
    send_frame(8'hEE, 1'b0, 1'b1, 1'b1, 0);
    chk("overrun_full17", 16'(full), 16'h0001);
    for (int i = 0; i < FIFO_DEPTH; i++) pop();
    chk("overrun_drained", 16'(empty), 16'h0001);
    send_frame(8'h11, 1'b0, 1'b1, 1'b1, 0);
    pop();
    chk("overrun_11", read_data, 16'h110B);

    send_frame(8'h99, 1'b0, 1'b1, 1'b1, 0);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    rx = 1'b0;
    repeat (BIT / 2) @(posedge clock);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    exp_q.delete();
    model_oe = 1'b0;
    last_exp = 16'h0000;
    chk("midreset_empty", 16'(empty), 16'h0001);
    chk("midreset_full", 16'(full), 16'h0000);
    chk("midreset_read_data", read_data, 16'h0000);
    reset = 1'b0;
    repeat (2 * BIT) @(posedge clock);
    #1;
    chk("midreset_nothing_pushed", 16'(empty), 16'h0001);
    send_frame(8'h77, 1'b0, 1'b1, 1'b1, 0);
    pop();
    chk("midreset_77", read_data, 16'h7709);

    for (int i = 0; i < 20; i++) begin
      d     = 8'($urandom_range(0, 255));
      pf    = ($urandom_range(0, 3) == 0);
      s1    = ($urandom_range(0, 4) != 0);
      s2    = ($urandom_range(0, 4) != 0);
      extra = s2 ? 0 : int'($urandom_range(0, BIT / 2));
      send_frame(d, pf, s1, s2, extra);
      chk("rand_full", 16'(full), 16'(exp_q.size() == FIFO_DEPTH));
      n_pop = int'($urandom_range(0, 2));
      for (int k = 0; k < n_pop; k++) pop();
    end
    while (exp_q.size() > 0) pop();
    pop();
    chk("final_empty", 16'(empty), 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
